// File: rtl/subleq_mem_arbiter.sv
// Round-robin arbiter sharing the SUBLEQ memory port between two req/ack requesters,
// with a bus watchdog that terminates transactions the memory never acknowledges.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_mem_arbiter #(
    parameter int unsigned W       = `WORD_SIZE,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req,
    input  logic         r0_load,
    input  logic         r0_store,
    input  logic [W-1:0] r0_addr,
    input  logic [W-1:0] r0_wdata,
    output logic         r0_ack,
    output logic [W-1:0] r0_rdata,
    input  logic         r1_req,
    input  logic         r1_load,
    input  logic         r1_store,
    input  logic [W-1:0] r1_addr,
    input  logic [W-1:0] r1_wdata,
    output logic         r1_ack,
    output logic [W-1:0] r1_rdata,
    output logic         mem_req,
    output logic         mem_load,
    output logic         mem_store,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_in,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_out,
    output logic [1:0]   grant,
    output logic         timeout
);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1, StDrain} state_e;

    localparam logic [CNT_W-1:0] CntMax = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               busy;
    logic               wd_fire;
    logic               own_req, own_load, own_store;
    logic [W-1:0]       own_addr, own_wdata;
    logic               own_ack;
    logic [W-1:0]       own_rdata;

    // last_q names the owner while in BUSYx and DRAIN
    always_comb begin
        own_req   = last_q ? r1_req   : r0_req;
        own_load  = last_q ? r1_load  : r0_load;
        own_store = last_q ? r1_store : r0_store;
        own_addr  = last_q ? r1_addr  : r0_addr;
        own_wdata = last_q ? r1_wdata : r0_wdata;
    end

    assign busy = (state_q == StBusy0) || (state_q == StBusy1);
    // mem_ack beats expiry; an aborting owner gets no synthetic ack
    assign wd_fire = busy && (TIMEOUT != 0) && (cnt_q == CntMax) && !mem_ack && own_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (r0_req && (!r1_req || last_q)) begin
                    state_d = StBusy0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (r1_req) begin
                    state_d = StBusy1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            StBusy0, StBusy1: begin
                if (mem_ack) begin
                    state_d = StDrain;
                end else if (!own_req) begin
                    state_d = StIdle;
                end else if (wd_fire) begin
                    state_d   = StDrain;
                    timeout_d = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (!own_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        r0_ack    = 1'b0;
        r0_rdata  = '0;
        r1_ack    = 1'b0;
        r1_rdata  = '0;
        mem_req   = 1'b0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        mem_addr  = '0;
        mem_in    = '0;
        grant     = 2'b00;
        timeout   = 1'b0;
        own_ack   = mem_ack || wd_fire;
        own_rdata = mem_ack ? mem_out : '0;
        if (!rst) begin
            timeout = timeout_q;
            unique case (state_q)
                StBusy0, StBusy1: begin
                    grant     = last_q ? 2'b10 : 2'b01;
                    mem_req   = own_req && !wd_fire;
                    mem_load  = own_load;
                    mem_store = own_store;
                    mem_addr  = own_addr;
                    mem_in    = own_wdata;
                    if (last_q) begin
                        r1_ack   = own_ack;
                        r1_rdata = own_rdata;
                    end else begin
                        r0_ack   = own_ack;
                        r0_rdata = own_rdata;
                    end
                end
                StDrain: grant = last_q ? 2'b10 : 2'b01;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/subleq_mem_arbiter.md
Name: subleq_mem_arbiter

Overview:
- Shares the single SUBLEQ memory port between two requesters using the req/ack handshake already used on the memory side of the MMIO decoder.
- Port 0 is the CPU path, i.e. the MMIO decoder's mem_* outputs. Port 1 is a secondary master such as the program loader or debug port.
- Arbitration is round-robin with one transaction granted at a time. A bus watchdog terminates transactions that never receive an ack.

Parameters:
- W, `WORD_SIZE: width of address and data words.
- TIMEOUT, 16: number of BUSY cycles without mem_ack before the watchdog fires. 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter. Requires TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- r0_req  in  1  requester 0 transaction request (level).
- r0_load  in  1  requester 0 read.
- r0_store  in  1  requester 0 write.
- r0_addr  in  W  requester 0 address.
- r0_wdata  in  W  requester 0 write data.
- r0_ack  out  1  requester 0 completion pulse.
- r0_rdata  out  W  requester 0 read data; valid while r0_ack=1.
- r1_req, r1_load, r1_store, r1_addr, r1_wdata, r1_ack, r1_rdata: same as r0_*, for requester 1.
- mem_req  out  1  memory request.
- mem_load  out  1  memory read.
- mem_store  out  1  memory write.
- mem_addr  out  W  memory address.
- mem_in  out  W  memory write data.
- mem_ack  in  1  memory completion.
- mem_out  in  W  memory read data.
- grant  out  2  one-hot current owner: bit0 = r0, bit1 = r1, 00 = none.
- timeout  out  1  sticky watchdog error flag.

Behaviour:
- Handshake contract for requesters:
  - Hold req and all qualifiers (load, store, addr, wdata) stable until ack is seen.
  - Deassert req for at least one cycle after ack before the next request.
- States: IDLE, BUSY0, BUSY1, DRAIN. A 1-bit `last` register records the most recent grant.
- Reset (rst=1 at the edge):
  - state=IDLE, last=1 (so r0 wins the first tie), counter=0, timeout=0.
  - While rst=1, all outputs are forced to 0 combinationally, including during a mid-transaction reset.
  - On the first cycle after rst falls, a still-held req is arbitrated afresh.
- IDLE:
  - All mem_* outputs 0, all acks 0, grant=00.
  - Only r0_req high -> BUSY0. Only r1_req high -> BUSY1.
  - Both high -> the port != last.
  - On any grant, update last and clear the counter.
  - Arbitration latency is exactly 1 cycle: mem_req rises the cycle after req is first seen in IDLE.
- BUSYx (x = granted port):
  - mem_req/load/store/addr/in are combinationally driven from rx_*.
  - rx_ack = mem_ack; rx_rdata = mem_out.
  - The non-granted port sees ack=0 and rdata=0.
  - grant is one-hot for x.
- BUSYx transitions:
  - mem_ack=1 -> DRAIN. The ack reaches the requester in the same cycle, so there is zero added ack latency.
  - rx_req=0 before ack (abort) -> IDLE; mem_req drops combinationally that cycle.
  - Otherwise the counter increments each cycle.
  - If TIMEOUT != 0 and the counter == TIMEOUT-1 with mem_ack=0:
    - rx_ack=1 and rx_rdata=0 for that cycle; mem_req is forced 0 that cycle.
    - timeout is set (sticky until rst); next state DRAIN.
- DRAIN:
  - mem_* outputs 0, acks 0; grant holds the previous owner.
  - Leave for IDLE when the owner's req=0.
  - This guarantees no ack is reused and provides fairness: a released requester cannot immediately re-win over a waiting one.
- The other port's req may rise at any time. It waits and is never dropped; its maximum wait is one full transaction plus DRAIN plus 1 cycle.
- Simultaneous mem_ack and watchdog expiry: mem_ack wins (normal completion, timeout not set).
- mem_load and mem_store both high are passed through unchanged; the arbiter does not validate them.
- Counter saturates at TIMEOUT-1 and never wraps.

Test Plan:
- Single read: r0_req=1, load, addr=0x10; memory acks after 3 cycles with mem_out=0x5A -> mem_req rises 1 cycle after r0_req; r0_ack pulses 1 cycle with r0_rdata=0x5A; grant=01; r1_ack stays 0.
- Tie after reset: r0_req and r1_req rise on the same cycle -> r0 is served first (grant=01), then r1 (grant=10) after r0 drops req; mem_addr switches to r1_addr only in BUSY1.
- Round-robin under load: both requesters re-request immediately after each ack for 6 transactions -> grant sequence strictly alternates 01,10,01,10,01,10.
- Watchdog: TIMEOUT=4, r1 store to addr=0x20, mem_ack never asserted -> r1_ack=1 with r1_rdata=0 on the 4th BUSY cycle; timeout=1 and stays 1; a subsequent r0 transaction completes normally.
- Abort and reset: r0 drops req in BUSY0 before ack -> mem_req=0 that cycle, state returns to IDLE. Separately, assert rst mid-BUSY1 -> all outputs 0 during rst; after release, held r1_req is re-granted after 1 cycle and timeout=0.
- Ack/expiry collision: TIMEOUT=3, mem_ack=1 on the expiry cycle -> normal completion with mem_out delivered; timeout stays 0.
